// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, command bytes and default timing.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    START   = 3'd2,
    BITS    = 3'd3,
    ACK     = 3'd4,
    RELEASE = 3'd5
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_LED   = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO  = 8'hEE;
  localparam logic [7:0] PS2_CMD_RESET = 8'hFF;

  // 20 x 6.4 us = 128 us clock inhibit; 2500 x 6.4 us = 16 ms frame timeout.
  localparam int PS2_INHIBIT_CYCLES = 20;
  localparam int PS2_TIMEOUT_CYCLES = 2500;

endpackage

// File: rtl/ps2_host_tx_if.sv
// System-side command handshake of the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] TX_DATA;
  logic       TX_REQ;
  logic       TX_BUSY;
  logic       TX_DONE;
  logic       TX_ERR;

  modport master (output TX_DATA, TX_REQ, input TX_BUSY, TX_DONE, TX_ERR);
  modport slave  (input TX_DATA, TX_REQ, output TX_BUSY, TX_DONE, TX_ERR);
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one open-collector PS/2 line plus a falling-edge
// detector. Lines idle high, so the flops reset to 1 to avoid a false edge.
module ps2_line_sync (
  input  logic DLY_CLK,
  input  logic RESET_N,
  input  logic line_i,
  output logic level_o,
  output logic fe_o
);

  logic [2:0] sync_q;

  // Shift the raw line through the synchroniser; bit 2 keeps the previous level.
  always_ff @(posedge DLY_CLK or negedge RESET_N) begin
    if (!RESET_N) sync_q <= 3'b111;
    else          sync_q <= {sync_q[1:0], line_i};
  end

  assign level_o = sync_q[1];
  assign fe_o    = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, start bit, 8 data bits LSB
// first, odd parity, stop bit, then device ACK check, with a frame timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic           DLY_CLK,
  input  logic           RESET_N,
  ps2_host_tx_if.slave   sys,
  input  logic           PS2_CLK_IN,
  input  logic           PS2_DAT_IN,
  output logic           PS2_CLK_OE,
  output logic           PS2_DAT_OE
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  ps2_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [9:0]  shift_q, shift_d;
  logic        dat_q, dat_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic clk_s, clk_fe, dat_s, dat_fe_unused;

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  ps2_line_sync u_clk_sync (
    .DLY_CLK (DLY_CLK), .RESET_N (RESET_N), .line_i (PS2_CLK_IN),
    .level_o (clk_s),   .fe_o    (clk_fe)
  );

  ps2_line_sync u_dat_sync (
    .DLY_CLK (DLY_CLK), .RESET_N (RESET_N), .line_i (PS2_DAT_IN),
    .level_o (dat_s),   .fe_o    (dat_fe_unused)
  );

  // State and datapath registers; reset releases both lines immediately.
  always_ff @(posedge DLY_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      dat_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      dat_q    <= dat_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: frame sequencing, bit shifting and timeout handling.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    dat_d    = dat_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        dat_d = 1'b0;
        if (sys.TX_REQ) begin
          state_d = INHIBIT;
          cnt_d   = '0;
          shift_d = {1'b1, ~^sys.TX_DATA, sys.TX_DATA};
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) state_d = START;
        else                   cnt_d   = sat_inc(cnt_q);
      end
      START: begin
        state_d  = BITS;
        cnt_d    = '0;
        bitcnt_d = '0;
        dat_d    = 1'b1;  // keep the start bit on the line until FE #1
      end
      BITS, ACK, RELEASE: begin
        cnt_d = sat_inc(cnt_q);
        if (cnt_q == TO_LAST) begin
          state_d = IDLE;
          dat_d   = 1'b0;
          err_d   = 1'b1;
        end else if (state_q == BITS) begin
          if (clk_fe) begin
            dat_d    = ~shift_q[0];
            shift_d  = {1'b1, shift_q[9:1]};
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd9) state_d = ACK;
          end
        end else if (state_q == ACK) begin
          if (clk_fe) begin
            if (!dat_s) state_d = RELEASE;
            else begin
              state_d = IDLE;
              err_d   = 1'b1;
            end
          end
        end else if (clk_s && dat_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        dat_d   = 1'b0;
      end
    endcase
  end

  assign sys.TX_BUSY = (state_q != IDLE);
  assign sys.TX_DONE = done_q;
  assign sys.TX_ERR  = err_q;
  assign PS2_CLK_OE  = (state_q == INHIBIT) || (state_q == START);
  assign PS2_DAT_OE  = (state_q == START) || dat_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector line model, behavioural PS/2 device,
// and a queue of expected line bits and frame outcomes.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  logic DLY_CLK = 1'b0;
  logic RESET_N = 1'b1;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic PS2_CLK_OE, PS2_DAT_OE;
  logic clk_line, dat_line;

  ps2_host_tx_if bus ();

  ps2_host_tx dut (
    .DLY_CLK    (DLY_CLK),
    .RESET_N    (RESET_N),
    .sys        (bus),
    .PS2_CLK_IN (clk_line),
    .PS2_DAT_IN (dat_line),
    .PS2_CLK_OE (PS2_CLK_OE),
    .PS2_DAT_OE (PS2_DAT_OE)
  );

  assign clk_line = ~(PS2_CLK_OE | dev_clk_low);
  assign dat_line = ~(PS2_DAT_OE | dev_dat_low);

  always #3200 DLY_CLK = ~DLY_CLK;  // 6.4 us period

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_q[$];
  int obs_q[$];
  int res_q[$];

  // Expected line bits for one frame: data LSB first, odd parity, stop.
  task automatic push_frame(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(int'(d[i]));
      if (d[i]) ones++;
    end
    exp_q.push_back((ones % 2 == 0) ? 1 : 0);
    exp_q.push_back(1);
  endtask

  // Device: 11 clocks at 80 us period, sampling data before each rising edge.
  task automatic device(input int ack);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack != 0) dev_dat_low = 1'b1;
      #40000;
      dev_clk_low = 1'b1;
      #40000;
      if (k <= 10) obs_q.push_back(int'(dat_line));
      dev_clk_low = 1'b0;
    end
    #40000;
    dev_dat_low = 1'b0;
  endtask

  task automatic send_req(input logic [7:0] d);
    @(negedge DLY_CLK);
    bus.TX_DATA = d;
    bus.TX_REQ  = 1'b1;
    @(negedge DLY_CLK);
    bus.TX_REQ  = 1'b0;
  endtask

  // mode 0: device ACKs; 1: device leaves data high on FE #11; 2: device silent.
  task automatic run_frame(input string name, input logic [7:0] d, input int mode, input int drop_req);
    int inh, dat_first, res, kk, busy_bad, busy_at_end, both, e, o;
    if (mode != 2) push_frame(d);
    res_q.push_back((mode == 0) ? 0 : 1);
    send_req(d);
    n_cmp++;
    if (bus.TX_BUSY !== 1'b1) begin n_fail++; $display("FAIL %s accept_busy: got %b want 1", name, bus.TX_BUSY); end
    inh = 0; dat_first = 0;
    while (PS2_CLK_OE === 1'b1 && inh < 100) begin
      inh++;
      if (PS2_DAT_OE === 1'b1 && dat_first == 0) dat_first = inh;
      if (drop_req != 0 && inh == 5) begin bus.TX_DATA = 8'h00; bus.TX_REQ = 1'b1; end
      else bus.TX_REQ = 1'b0;
      @(negedge DLY_CLK);
    end
    bus.TX_REQ = 1'b0;
    n_cmp++;
    if (inh !== 21) begin n_fail++; $display("FAIL %s inhibit_len: got %0d want 21", name, inh); end
    n_cmp++;
    if (dat_first !== 21) begin n_fail++; $display("FAIL %s start_bit_cycle: got %0d want 21", name, dat_first); end
    res = -1; kk = 1; busy_bad = 0; busy_at_end = 1; both = 0;
    fork
      begin
        if (mode != 2) device((mode == 0) ? 1 : 0);
      end
      begin
        while (kk <= 4000) begin
          if (bus.TX_DONE === 1'b1 || bus.TX_ERR === 1'b1) begin
            res = (bus.TX_DONE === 1'b1) ? 0 : 1;
            both = (bus.TX_DONE === 1'b1 && bus.TX_ERR === 1'b1) ? 1 : 0;
            busy_at_end = int'(bus.TX_BUSY);
            break;
          end
          if (bus.TX_BUSY !== 1'b1) busy_bad++;
          @(negedge DLY_CLK);
          kk++;
        end
      end
    join
    e = res_q.pop_front();
    n_cmp++;
    if (res !== e) begin n_fail++; $display("FAIL %s outcome: got %0d want %0d (0=done 1=err)", name, res, e); end
    n_cmp++;
    if (both !== 0) begin n_fail++; $display("FAIL %s done_and_err: got %0d want 0", name, both); end
    n_cmp++;
    if (busy_bad !== 0 || busy_at_end !== 0) begin
      n_fail++; $display("FAIL %s busy_window: low %0d cycles, busy at end %0d", name, busy_bad, busy_at_end);
    end
    n_cmp++;
    if (PS2_CLK_OE !== 1'b0 || PS2_DAT_OE !== 1'b0) begin
      n_fail++; $display("FAIL %s lines_released: clk_oe %b dat_oe %b want 0 0", name, PS2_CLK_OE, PS2_DAT_OE);
    end
    if (mode == 2) begin
      n_cmp++;
      if (kk - 1 !== 2500) begin n_fail++; $display("FAIL %s timeout_cycles: got %0d want 2500", name, kk - 1); end
    end
    @(negedge DLY_CLK);
    n_cmp++;
    if (bus.TX_DONE !== 1'b0 || bus.TX_ERR !== 1'b0) begin
      n_fail++; $display("FAIL %s pulse_width: done %b err %b want 0 0", name, bus.TX_DONE, bus.TX_ERR);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL %s line_bit%0d: got none want %0d", name, i, e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL %s line_bit%0d: got %0d want %0d", name, i, o, e); end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_reset();
    bus.TX_REQ = 1'b0; bus.TX_DATA = 8'h00;
    #100 RESET_N = 1'b0;
    repeat (3) @(negedge DLY_CLK);
    n_cmp++;
    if (PS2_CLK_OE !== 1'b0) begin n_fail++; $display("FAIL reset clk_oe: got %b want 0", PS2_CLK_OE); end
    n_cmp++;
    if (PS2_DAT_OE !== 1'b0) begin n_fail++; $display("FAIL reset dat_oe: got %b want 0", PS2_DAT_OE); end
    n_cmp++;
    if (bus.TX_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", bus.TX_BUSY); end
    n_cmp++;
    if (bus.TX_DONE !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", bus.TX_DONE); end
    n_cmp++;
    if (bus.TX_ERR !== 1'b0) begin n_fail++; $display("FAIL reset err: got %b want 0", bus.TX_ERR); end
    RESET_N = 1'b1;
    repeat (3) @(negedge DLY_CLK);
  endtask

  task automatic test_led();
    run_frame("led", PS2_CMD_LED, 0, 0);
  endtask

  task automatic test_parity();
    run_frame("par02", 8'h02, 0, 0);
    run_frame("par00", 8'h00, 0, 0);
  endtask

  task automatic test_timeout();
    run_frame("timeout", PS2_CMD_ECHO, 2, 0);
  endtask

  task automatic test_nack();
    run_frame("nack", PS2_CMD_ECHO, 1, 0);
  endtask

  task automatic test_reset_midframe();
    int inh, pulses;
    send_req(8'h55);
    inh = 0;
    while (PS2_CLK_OE === 1'b1 && inh < 100) begin inh++; @(negedge DLY_CLK); end
    for (int k = 1; k <= 5; k++) begin
      #40000;
      dev_clk_low = 1'b1;
      if (k < 5) begin #40000; dev_clk_low = 1'b0; end
    end
    #20000;
    RESET_N = 1'b0;
    #1;
    n_cmp++;
    if ({PS2_CLK_OE, PS2_DAT_OE, bus.TX_BUSY, bus.TX_DONE, bus.TX_ERR} !== 5'b0) begin
      n_fail++;
      $display("FAIL midreset outputs: got %b want 00000",
               {PS2_CLK_OE, PS2_DAT_OE, bus.TX_BUSY, bus.TX_DONE, bus.TX_ERR});
    end
    #19000;
    dev_clk_low = 1'b0;
    @(negedge DLY_CLK);
    RESET_N = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge DLY_CLK);
      if (bus.TX_DONE !== 1'b0 || bus.TX_ERR !== 1'b0 || bus.TX_BUSY !== 1'b0) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin n_fail++; $display("FAIL midreset quiet: got %0d active cycles want 0", pulses); end
  endtask

  task automatic test_busy_drop();
    int active;
    run_frame("reset_cmd", PS2_CMD_RESET, 0, 1);
    active = 0;
    repeat (8) begin
      @(negedge DLY_CLK);
      if (bus.TX_BUSY !== 1'b0 || PS2_CLK_OE !== 1'b0) active++;
    end
    n_cmp++;
    if (active !== 0) begin n_fail++; $display("FAIL dropped_req: got %0d busy cycles want 0", active); end
  endtask

  initial begin
    test_reset();
    test_led();
    test_parity();
    test_timeout();
    test_nack();
    test_reset_midframe();
    test_busy_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
